vmc_multi_product: RTL and testbench

Parametrised next-generation vending controller. Accepts ₹1/₹2/₹5 coin pulses into a bounded credit register and vends one of N_PROD products, each with its own price. Supports auto-vend or explicit-request modes and a cancel/refund path. Change and refunds are returned as a serial coin stream, largest coin first. Sits between the coin acceptor front end and the dispenser/change-hopper drivers.

---
 rtl/vmc_pkg.sv | 14 +
 rtl/vmc_change_dispenser.sv | 50 +++++
 rtl/vmc_multi_product.sv | 149 ++++++++++++++
 tb/tb_vmc_multi_product.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vmc_pkg.sv
// Shared types and constants for the multi-product vending controller.
package vmc_pkg;
    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

    typedef enum logic [1:0] {
        CHG_NONE = 2'b00,
        CHG_1    = 2'b01,
        CHG_2    = 2'b10
    } chg_t;

    localparam int COIN_1_VAL = 1;
    localparam int COIN_2_VAL = 2;
    localparam int COIN_5_VAL = 5;
endpackage

// File: rtl/vmc_change_dispenser.sv
// Change countdown: pays out the loaded amount one coin per cycle, ₹2 coins first.
module vmc_change_dispenser
    import vmc_pkg::*;
#(
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic [CREDIT_W-1:0] amount,
    output logic [1:0]          change,
    output logic [CREDIT_W-1:0] rem_next,
    output logic                done
);
    logic [CREDIT_W-1:0] remaining;
    logic [CREDIT_W-1:0] src;
    chg_t                code;
    chg_t                change_q;

    // The first coin is emitted on the same edge as the load so the payout
    // takes exactly ceil(amount/2) cycles.
    always_comb begin
        src      = load ? amount : remaining;
        code     = CHG_NONE;
        rem_next = src;
        if (src >= CREDIT_W'(2)) begin
            code     = CHG_2;
            rem_next = src - CREDIT_W'(2);
        end else if (src != '0) begin
            code     = CHG_1;
            rem_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            change_q  <= CHG_NONE;
        end else if (load || step) begin
            remaining <= rem_next;
            change_q  <= code;
        end else begin
            change_q  <= CHG_NONE;
        end
    end

    assign change = change_q;
    assign done   = (remaining == '0);
endmodule

// File: rtl/vmc_multi_product.sv
// Vending controller: coin credit, per-product prices, auto/explicit vend, refund.
module vmc_multi_product
    import vmc_pkg::*;
#(
    parameter int                         N_PROD     = 2,
    parameter int                         SEL_W      = 2,
    parameter int                         CREDIT_W   = 4,
    parameter int                         MAX_CREDIT = 9,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICES     = {4'd3, 4'd5},
    parameter bit                         AUTO_VEND  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_1,
    input  logic                coin_2,
    input  logic                coin_5,
    input  logic [SEL_W-1:0]    sel,
    input  logic                vend_req,
    input  logic                cancel,
    output logic                product,
    output logic [SEL_W-1:0]    product_id,
    output logic [1:0]          change,
    output logic                coin_reject,
    output logic                sel_error,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);
    localparam int CW1 = CREDIT_W + 1;

    state_t              state, state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic                product_d, coin_reject_d, sel_error_d, busy_d;
    logic [SEL_W-1:0]    product_id_d;

    logic                coin_any;
    logic [CW1-1:0]      coin_sum, new_credit;
    logic [CREDIT_W-1:0] eval_credit, price;
    logic                sel_ok, over;
    int                  sel_idx;

    logic                disp_load, disp_step, disp_done;
    logic [CREDIT_W-1:0] disp_amount, disp_rem_next;

    assign coin_any = coin_1 | coin_2 | coin_5;

    always_comb begin
        coin_sum = '0;
        if (coin_1) coin_sum = coin_sum + CW1'(COIN_1_VAL);
        if (coin_2) coin_sum = coin_sum + CW1'(COIN_2_VAL);
        if (coin_5) coin_sum = coin_sum + CW1'(COIN_5_VAL);
        new_credit = {1'b0, credit} + coin_sum;
    end

    assign over        = (new_credit > CW1'(MAX_CREDIT));
    assign eval_credit = over ? credit : new_credit[CREDIT_W-1:0];
    assign sel_idx     = int'(sel);
    assign sel_ok      = (sel_idx < N_PROD);

    always_comb begin
        price = '0;
        if (sel_ok) price = PRICES[sel_idx*CREDIT_W +: CREDIT_W];
    end

    always_comb begin
        state_d       = state;
        credit_d      = credit;
        product_d     = 1'b0;
        product_id_d  = product_id;
        coin_reject_d = 1'b0;
        sel_error_d   = 1'b0;
        disp_load     = 1'b0;
        disp_step     = 1'b0;
        disp_amount   = credit;
        case (state)
            COLLECT: begin
                if (cancel) begin
                    coin_reject_d = coin_any;
                    if (credit != '0) begin
                        disp_load = 1'b1;
                        credit_d  = disp_rem_next;
                        state_d   = CHANGE;
                    end
                end else begin
                    coin_reject_d = over;
                    credit_d      = eval_credit;
                    if (sel_ok) begin
                        if ((AUTO_VEND || vend_req) && eval_credit >= price) begin
                            credit_d     = eval_credit - price;
                            product_d    = 1'b1;
                            product_id_d = sel;
                            state_d      = VEND;
                        end
                    end else if (!AUTO_VEND && vend_req) begin
                        sel_error_d = 1'b1;
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_any;
                if (credit != '0) begin
                    disp_load = 1'b1;
                    credit_d  = disp_rem_next;
                    state_d   = CHANGE;
                end else begin
                    state_d = COLLECT;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_any;
                disp_step     = 1'b1;
                credit_d      = disp_rem_next;
                if (disp_done) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
        busy_d = (state_d != COLLECT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= COLLECT;
            credit      <= '0;
            product     <= 1'b0;
            product_id  <= '0;
            coin_reject <= 1'b0;
            sel_error   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            credit      <= credit_d;
            product     <= product_d;
            product_id  <= product_id_d;
            coin_reject <= coin_reject_d;
            sel_error   <= sel_error_d;
            busy        <= busy_d;
        end
    end

    vmc_change_dispenser #(.CREDIT_W(CREDIT_W)) u_disp (
        .clk      (clk),
        .reset    (reset),
        .load     (disp_load),
        .step     (disp_step),
        .amount   (disp_amount),
        .change   (change),
        .rem_next (disp_rem_next),
        .done     (disp_done)
    );
endmodule

// File: tb/tb_vmc_multi_product.sv
// Directed bench: one auto-vend and one explicit-request controller share stimulus.
module tb_vmc_multi_product;
    logic       clk = 1'b0;
    logic       reset;
    logic       coin_1, coin_2, coin_5, vend_req, cancel;
    logic [1:0] sel;

    logic       a_product, a_rej, a_serr, a_busy;
    logic [1:0] a_pid, a_change;
    logic [3:0] a_credit;
    logic       m_product, m_rej, m_serr, m_busy;
    logic [1:0] m_pid, m_change;
    logic [3:0] m_credit;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // product 0 costs 3, product 1 costs 5
    vmc_multi_product #(.N_PROD(2), .SEL_W(2), .CREDIT_W(4), .MAX_CREDIT(9),
                        .PRICES(8'h53), .AUTO_VEND(1'b1)) u_auto (
        .clk(clk), .reset(reset), .coin_1(coin_1), .coin_2(coin_2), .coin_5(coin_5),
        .sel(sel), .vend_req(vend_req), .cancel(cancel),
        .product(a_product), .product_id(a_pid), .change(a_change),
        .coin_reject(a_rej), .sel_error(a_serr), .credit(a_credit), .busy(a_busy)
    );

    vmc_multi_product #(.N_PROD(2), .SEL_W(2), .CREDIT_W(4), .MAX_CREDIT(9),
                        .PRICES(8'h53), .AUTO_VEND(1'b0)) u_man (
        .clk(clk), .reset(reset), .coin_1(coin_1), .coin_2(coin_2), .coin_5(coin_5),
        .sel(sel), .vend_req(vend_req), .cancel(cancel),
        .product(m_product), .product_id(m_pid), .change(m_change),
        .coin_reject(m_rej), .sel_error(m_serr), .credit(m_credit), .busy(m_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        coin_1 = 0; coin_2 = 0; coin_5 = 0; vend_req = 0; cancel = 0;
    endtask

    task automatic do_reset;
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        sel   = 2'd1;
        do_reset();

        check("rst_credit", a_credit, 0);
        check("rst_product", a_product, 0);
        check("rst_change", a_change, 0);
        check("rst_busy", a_busy, 0);
        check("rst_reject", m_rej, 0);
        check("rst_selerr", m_serr, 0);

        // 1+2+2 reaches price 5 exactly
        coin_1 = 1; tick(); coin_1 = 0;
        check("t1_credit1", a_credit, 1);
        coin_2 = 1; tick(); tick(); coin_2 = 0;
        check("t1_product", a_product, 1);
        check("t1_pid", a_pid, 1);
        check("t1_credit_vend", a_credit, 0);
        check("t1_busy_vend", a_busy, 1);
        tick();
        check("t1_product_off", a_product, 0);
        check("t1_no_change", a_change, 0);
        check("t1_idle", a_busy, 0);

        // 2+2+2 = 6, vend 5, one ₹1 back
        do_reset();
        coin_2 = 1; tick(); tick();
        check("t2_credit4", a_credit, 4);
        tick(); coin_2 = 0;
        check("t2_product", a_product, 1);
        check("t2_credit_vend", a_credit, 1);
        tick();
        check("t2_change1", a_change, 2'b01);
        check("t2_product_off", a_product, 0);
        check("t2_credit0", a_credit, 0);
        tick();
        check("t2_change_done", a_change, 0);
        check("t2_idle", a_busy, 0);

        // explicit request: 5 in, buy product 0 for 3, ₹2 back
        do_reset();
        sel = 2'd0;
        coin_5 = 1; tick(); coin_5 = 0;
        check("t3_credit5", m_credit, 5);
        check("t3_no_auto", m_product, 0);
        vend_req = 1; tick(); vend_req = 0;
        check("t3_product", m_product, 1);
        check("t3_pid", m_pid, 0);
        check("t3_credit_vend", m_credit, 2);
        tick();
        check("t3_change2", m_change, 2'b10);
        check("t3_credit0", m_credit, 0);
        tick();
        check("t3_change_done", m_change, 0);
        check("t3_idle", m_busy, 0);

        // simultaneous 2+1, then cancel -> ₹2, ₹1
        do_reset();
        coin_2 = 1; coin_1 = 1; tick(); coin_2 = 0; coin_1 = 0;
        check("t4_credit3", m_credit, 3);
        cancel = 1; tick(); cancel = 0;
        check("t4_change2", m_change, 2'b10);
        check("t4_credit1", m_credit, 1);
        check("t4_busy", m_busy, 1);
        check("t4_no_product_a", m_product, 0);
        tick();
        check("t4_change1", m_change, 2'b01);
        check("t4_credit0", m_credit, 0);
        check("t4_no_product_b", m_product, 0);
        tick();
        check("t4_change_done", m_change, 0);
        check("t4_idle", m_busy, 0);

        // credit 8: coin_2 overflows, out-of-range request flags
        do_reset();
        sel = 2'd1;
        coin_5 = 1; tick(); coin_5 = 0;
        coin_2 = 1; tick(); coin_2 = 0;
        coin_1 = 1; tick(); coin_1 = 0;
        check("t5_credit8", m_credit, 8);
        coin_2 = 1; tick(); coin_2 = 0;
        check("t5_reject", m_rej, 1);
        check("t5_credit_kept", m_credit, 8);
        sel = 2'd3; vend_req = 1; tick(); vend_req = 0;
        check("t5_reject_off", m_rej, 0);
        check("t5_selerr", m_serr, 1);
        check("t5_credit_kept2", m_credit, 8);
        check("t5_no_product", m_product, 0);
        check("t5_auto_no_flag", a_serr, 0);
        tick();
        check("t5_selerr_off", m_serr, 0);

        // coin during CHANGE rejected; reset mid-CHANGE clears at once
        do_reset();
        sel = 2'd1;
        coin_5 = 1; tick(); coin_5 = 0;
        coin_1 = 1; tick(); coin_1 = 0;
        check("t6_credit6", m_credit, 6);
        cancel = 1; tick(); cancel = 0;
        check("t6_change2a", m_change, 2'b10);
        check("t6_credit4", m_credit, 4);
        coin_5 = 1; tick(); coin_5 = 0;
        check("t6_reject", m_rej, 1);
        check("t6_change2b", m_change, 2'b10);
        check("t6_credit2", m_credit, 2);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_credit", m_credit, 0);
        check("t6_rst_change", m_change, 0);
        check("t6_rst_busy", m_busy, 0);
        tick();
        reset = 1'b1;
        coin_1 = 1; tick(); coin_1 = 0;
        check("t6_collect_credit", m_credit, 1);
        check("t6_collect_busy", m_busy, 0);
        check("t6_collect_change", m_change, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
